mavg_ctrl: RTL and testbench

//  Sequencer/detector wrapped around one moving-average instance in the openofdm_rx chain
//  (power / autocorrelation smoothing ahead of packet detection).

---
 rtl/mavg_ctrl.sv | 136 +++++++++++++
 tb/tb_mavg_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mavg_ctrl.sv
// Sequencer/threshold detector around one moving-average instance: flush, fill, armed compare, holdoff.
// Optional build macro MAVG_CTRL_HYST_EN: leaving HOLD also needs the average to fall below thresh_low.
module mavg_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WINDOW_SHIFT = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_WIDTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         restart,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic [HOLD_WIDTH-1:0]        holdoff,
  input  logic signed [DATA_WIDTH-1:0] thresh_low,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_strobe,
  output logic                         mavg_reset,
  output logic                         mavg_enable,
  output logic signed [DATA_WIDTH-1:0] mavg_data_in,
  output logic                         mavg_in_strobe,
  input  logic signed [DATA_WIDTH-1:0] mavg_data_out,
  input  logic                         mavg_out_strobe,
  output logic signed [DATA_WIDTH-1:0] avg_out,
  output logic                         avg_valid,
  output logic                         trigger,
  output logic                         armed,
  output logic [2:0]                   state,
  output logic [15:0]                  trig_count,
  output logic [WINDOW_SHIFT:0]        win_size
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_FILL  = 3'd2,
    S_ARMED = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [HOLD_WIDTH-1:0] hold_cnt_q;
  logic                  capture, fire, hold_dec;
  logic                  rearm_ok;
  logic                  running;

`ifdef MAVG_CTRL_HYST_EN
  assign rearm_ok = (mavg_data_out < thresh_low);
`else
  assign rearm_ok = 1'b1;
  logic unused_thresh_low;
  assign unused_thresh_low = ^thresh_low;
`endif

  // Next state and per-cycle actions; enable and restart override everything.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    capture     = 1'b0;
    fire        = 1'b0;
    hold_dec    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (restart) begin
      state_d     = S_FLUSH;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
        S_FLUSH: begin
          if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) state_d = S_FILL;
          else flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
        S_FILL: begin
          if (mavg_out_strobe) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (mavg_out_strobe) begin
            capture = 1'b1;
            if (mavg_data_out >= threshold) begin
              fire    = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (mavg_out_strobe) begin
            capture = 1'b1;
            if (hold_cnt_q == '0 && rearm_ok) state_d = S_ARMED;
            else if (hold_cnt_q != '0) hold_dec = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
      trig_count  <= '0;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      trigger     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      avg_valid   <= capture;
      trigger     <= fire;
      if (capture) avg_out <= mavg_data_out;
      if (fire) hold_cnt_q <= holdoff;
      else if (hold_dec) hold_cnt_q <= hold_cnt_q - HOLD_WIDTH'(1);
      // Count is zero whenever the FSM is seen in FLUSH, including its entry cycle.
      if (state_d == S_FLUSH) trig_count <= '0;
      else if (fire && trig_count != 16'hFFFF) trig_count <= trig_count + 16'd1;
    end
  end

  assign running        = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_HOLD);
  assign mavg_reset     = !running;
  assign mavg_enable    = running;
  assign mavg_in_strobe = running && sample_strobe;
  assign mavg_data_in   = sample_in;
  assign armed          = (state_q == S_ARMED);
  assign state          = state_q;
  assign win_size       = (WINDOW_SHIFT + 1)'(1) << WINDOW_SHIFT;

endmodule

// File: tb/tb_mavg_ctrl.sv
// Bench for mavg_ctrl: behavioural averager, event-level reference model and scoreboard monitor.
module tb_mavg_ctrl;

  localparam int unsigned DW = 32;
  localparam int          FLUSH_N = 2;

  logic                 clock = 1'b0;
  logic                 reset, enable, restart, sample_strobe;
  logic signed [DW-1:0] threshold, thresh_low, sample_in;
  logic [15:0]          holdoff;
  logic                 mavg_reset, mavg_enable, mavg_in_strobe;
  logic signed [DW-1:0] mavg_data_in, mavg_data_out, avg_out;
  logic                 mavg_out_strobe, avg_valid, trigger, armed;
  logic [2:0]           state;
  logic [15:0]          trig_count;
  logic [4:0]           win_size;

  always #5 clock = ~clock;

  mavg_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable), .restart(restart),
    .threshold(threshold), .holdoff(holdoff), .thresh_low(thresh_low),
    .sample_in(sample_in), .sample_strobe(sample_strobe),
    .mavg_reset(mavg_reset), .mavg_enable(mavg_enable), .mavg_data_in(mavg_data_in),
    .mavg_in_strobe(mavg_in_strobe), .mavg_data_out(mavg_data_out),
    .mavg_out_strobe(mavg_out_strobe), .avg_out(avg_out), .avg_valid(avg_valid),
    .trigger(trigger), .armed(armed), .state(state), .trig_count(trig_count),
    .win_size(win_size)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // 16-deep moving average: emits the mean once the window is full, one cycle after each input.
  longint win[$];
  always @(posedge clock) begin
    longint s;
    if (mavg_reset) begin
      win.delete();
      mavg_out_strobe <= 1'b0;
      mavg_data_out   <= '0;
    end else begin
      mavg_out_strobe <= 1'b0;
      if (mavg_enable && mavg_in_strobe) begin
        win.push_back(longint'(mavg_data_in));
        if (win.size() > 16) void'(win.pop_front());
        if (win.size() == 16) begin
          s = 0;
          foreach (win[i]) s += win[i];
          mavg_out_strobe <= 1'b1;
          mavg_data_out   <= DW'(s >>> 4);
        end
      end
    end
  end

  // Reference model, stepped once per averager event / control input at each clock edge.
  typedef struct {
    longint avg;
    bit     trig;
    longint tc;
  } exp_t;
  exp_t exp_q[$];
  int   ph = 0;
  int   flush_left = 0;
  int   hold_left = 0;
  int   tcount = 0;
  bit   mon_on = 1'b0;

  always @(posedge clock) begin
    bit hit, rearm;
    if (reset) begin
      ph = 0;
      tcount = 0;
      exp_q.delete();
    end else if (!enable) begin
      ph = 0;
    end else if (restart || ph == 0) begin
      ph = 1;
      flush_left = FLUSH_N;
      tcount = 0;
    end else if (ph == 1) begin
      flush_left--;
      if (flush_left == 0) ph = 2;
    end else if (mavg_out_strobe) begin
      if (ph == 2) begin
        ph = 3;
      end else if (ph == 3) begin
        hit = (mavg_data_out >= threshold);
        if (hit) begin
          tcount = (tcount < 65535) ? tcount + 1 : 65535;
          hold_left = int'(holdoff);
          ph = 4;
        end
        exp_q.push_back('{longint'(mavg_data_out), hit, longint'(tcount)});
      end else begin
        exp_q.push_back('{longint'(mavg_data_out), 1'b0, longint'(tcount)});
`ifdef MAVG_CTRL_HYST_EN
        rearm = (mavg_data_out < thresh_low);
`else
        rearm = 1'b1;
`endif
        if (hold_left == 0 && rearm) ph = 3;
        else if (hold_left > 0) hold_left--;
      end
    end
  end

  // Scoreboard monitor on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (mon_on) begin
      check("state", longint'(state), longint'(ph));
      check("trig_count", longint'(trig_count), longint'(tcount));
      check("mavg_reset", longint'(mavg_reset), longint'(ph <= 1));
      if (avg_valid) begin
        check("expect_pending", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("avg_out", longint'(avg_out), e.avg);
          check("trigger", longint'(trigger), longint'(e.trig));
          check("valid_trig_count", longint'(trig_count), e.tc);
        end
      end else begin
        check("trigger_without_valid", longint'(trigger), 0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nv, got;
    int thr_tab[5];
    int lvl_tab[6];
    int level;
    thr_tab = '{0, 80, 100, 150, -50};
    lvl_tab = '{0, 50, 120, 200, -300, 90};

    reset = 1'b1; enable = 1'b0; restart = 1'b0; sample_strobe = 1'b0;
    threshold = 100; thresh_low = 80; sample_in = 50; holdoff = 16'd3;
    step();
    mon_on = 1'b1;
    step(); step();
    check("rst_state", longint'(state), 0);
    check("rst_mavg_reset", longint'(mavg_reset), 1);
    check("rst_avg_out", longint'(avg_out), 0);
    check("rst_avg_valid", longint'(avg_valid), 0);
    check("rst_trig_count", longint'(trig_count), 0);
    check("rst_mavg_enable", longint'(mavg_enable), 0);
    check("win_size", longint'(win_size), 16);

    // Bring-up with constant 50: two flush cycles, then armed once the window fills.
    reset = 1'b0; enable = 1'b1; sample_strobe = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state == 3'd1) n++;
    end
    check("flush_cycles", n, 2);
    check("armed_after_fill", longint'(armed), 1);

    // Step to 200: first trigger when six 200s are in the window, mean 1700/16.
    sample_in = 200;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (trigger) got = 1;
    end
    check("trig1_seen", got, 1);
    check("trig1_avg", longint'(avg_out), 106);
    check("trig1_count", longint'(trig_count), 1);
    check("trig1_state", longint'(state), 4);

`ifndef MAVG_CTRL_HYST_EN
    // holdoff=3: four ignored averages after the trigger, then the next one fires.
    got = 0; nv = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      step();
      if (trigger) got = 1;
      else if (avg_valid) nv++;
    end
    check("trig2_seen", got, 1);
    check("trig2_count", longint'(trig_count), 2);
    check("valids_between", nv, 4);
`else
    repeat (30) step();
    check("hyst_hold", longint'(state), 4);
    sample_in = 0;
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      step();
      if (state == 3'd3) got = 1;
    end
    check("hyst_rearm", got, 1);
    sample_in = 200;
`endif

    // Drop enable while in HOLD.
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      if (state == 3'd4) got = 1;
      else step();
    end
    check("hold_reached", got, 1);
    enable = 1'b0;
    step();
    check("dis_state", longint'(state), 0);
    check("dis_mavg_reset", longint'(mavg_reset), 1);
    check("dis_in_strobe", longint'(mavg_in_strobe), 0);
    check("dis_mavg_enable", longint'(mavg_enable), 0);
    enable = 1'b1;

    // Restart coincident with a crossing strobe suppresses the trigger.
    holdoff = 16'd0;
    got = 0;
    for (int i = 0; i < 80 && got == 0; i++) begin
      if (state == 3'd3 && mavg_out_strobe && mavg_data_out >= threshold) got = 1;
      else step();
    end
    check("cross_armed", got, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rst_cross_state", longint'(state), 1);
    check("rst_cross_count", longint'(trig_count), 0);
    check("rst_cross_trigger", longint'(trigger), 0);

    // Randomised traffic against the model.
    level = 120;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      restart = (r < 8);
      if (r >= 996) enable = 1'b0;
      else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
      sample_strobe = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) level = lvl_tab[$urandom_range(0, 5)];
      sample_in = level + int'($urandom_range(0, 40)) - 20;
      if ($urandom_range(0, 149) == 0) threshold = thr_tab[$urandom_range(0, 4)];
      if ($urandom_range(0, 99) == 0) holdoff = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 149) == 0) thresh_low = thr_tab[$urandom_range(0, 4)];
      step();
    end

    enable = 1'b0; restart = 1'b0; sample_strobe = 1'b0;
    repeat (5) step();
    check("queue_drained", longint'(exp_q.size()), 0);
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
